// File: rtl/fifo_stream_adapter.sv
// Turns a registered-read sync FIFO (one cycle of read latency) into a valid/ready stream.
// A two-entry skid buffer (head = oldest, tail) absorbs the word already in flight when downstream stalls.
module fifo_stream_adapter #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [1:0]        buf_count,
    output logic [15:0]       beat_cnt
);

    logic [1:0]        count;
    logic              inflight;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] tail;
    logic [1:0]        committed;
    logic              pop;

    // Words already owned by the adapter: buffered plus the one arriving this cycle.
    assign committed = count + {1'b0, inflight};
    assign pop       = m_valid && m_ready;

    // A pop this cycle frees one slot, so a full commitment may still issue a read.
    assign fifo_rd_en = !rst && !fifo_empty &&
                        ((committed < 2'd2) || ((committed == 2'd2) && pop));

    assign m_valid   = (count != 2'd0);
    assign m_data    = head;
    assign buf_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 16'd0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

    // Buffer update: inflight means fifo_rd_data holds a fresh word that must be captured now.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (inflight) begin
                        head  <= fifo_rd_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && pop) begin
                        head <= fifo_rd_data;
                    end else if (inflight) begin
                        tail  <= fifo_rd_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full with a write can only coincide with a pop, since committed never exceeds two.
                    if (pop) begin
                        head <= tail;
                        if (inflight) begin
                            tail <= fifo_rd_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: begin
                    count <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a behavioural sync FIFO feeds the adapter, and a
// negedge monitor checks every downstream transfer against a queue of expected words.
module tb_fifo_stream_adapter;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  buf_count;
    logic [15:0] beat_cnt;

    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic [15:0] fifo_q[$];

    logic [15:0] exp_q[$];
    int          vectors;
    int          miscompares;
    int          xfer_count;
    logic [15:0] exp_beats;
    logic        prev_stall;
    logic [15:0] prev_data;

    fifo_stream_adapter #(.DWIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .buf_count    (buf_count),
        .beat_cnt     (beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream sync FIFO model: registered read data, empty flag updated at the edge.
    initial begin
        fifo_rd_data = 16'h0000;
        fifo_empty   = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_rd_data <= 16'h0000;
            fifo_empty   <= 1'b1;
        end else begin
            if (fifo_rd_en && (fifo_q.size() > 0)) begin
                fifo_rd_data <= fifo_q.pop_front();
            end
            if (fifo_wr_en) begin
                fifo_q.push_back(fifo_wr_data);
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Write one word into the FIFO and record it as the next expected stream word.
    task automatic applyStimulus(input logic [15:0] word);
        fifo_wr_en   = 1'b1;
        fifo_wr_data = word;
        exp_q.push_back(word);
        @(posedge clk);
        #1;
        fifo_wr_en = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_words_left", exp_q.size(), 0);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        stepCycles(2);
        rst = 1'b0;
    endtask

    // Monitor: compares each transfer with the scoreboard and tracks the expected beat count.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_beats  = 16'h0000;
            prev_stall = 1'b0;
            checkOutput("rd_en_in_reset", {31'd0, fifo_rd_en}, 0);
        end else begin
            checkOutput("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 0);
            checkOutput("valid_vs_count", {31'd0, m_valid}, {31'd0, buf_count != 2'd0});
            if (prev_stall) begin
                checkOutput("hold_valid", {31'd0, m_valid}, 1);
                checkOutput("hold_data", {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", {16'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("stream_word", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
                checkOutput("beat_cnt_at_xfer", {16'd0, beat_cnt}, {16'd0, exp_beats});
                exp_beats  = exp_beats + 16'd1;
                xfer_count = xfer_count + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        int x0;
        vectors      = 0;
        miscompares  = 0;
        xfer_count   = 0;
        exp_beats    = 16'h0000;
        prev_stall   = 1'b0;
        prev_data    = 16'h0000;
        rst          = 1'b1;
        m_ready      = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 16'h0000;
        stepCycles(3);
        rst = 1'b0;

        $display("[TB] reset state and empty FIFO");
        @(negedge clk);
        checkOutput("reset_m_valid", {31'd0, m_valid}, 0);
        checkOutput("reset_m_data", {16'd0, m_data}, 0);
        checkOutput("reset_buf_count", {30'd0, buf_count}, 0);
        checkOutput("reset_beat_cnt", {16'd0, beat_cnt}, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("empty_idle", {30'd0, fifo_rd_en, m_valid}, 0);
        end
        @(posedge clk);
        #1;

        $display("[TB] fill with 0x0001..0x0003");
        m_ready = 1'b1;
        fork
            begin
                applyStimulus(16'h0001);
                applyStimulus(16'h0002);
                applyStimulus(16'h0003);
            end
            begin
                @(negedge clk);
                checkOutput("fill_rd_en_c0", {31'd0, fifo_rd_en}, 0);
                @(negedge clk);
                checkOutput("fill_rd_en_c1", {31'd0, fifo_rd_en}, 1);
                checkOutput("fill_valid_c1", {31'd0, m_valid}, 0);
                @(negedge clk);
                checkOutput("fill_valid_c2", {31'd0, m_valid}, 0);
                @(negedge clk);
                checkOutput("fill_word1", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0001});
                @(negedge clk);
                checkOutput("fill_word2", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0002});
                @(negedge clk);
                checkOutput("fill_word3", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0003});
                @(negedge clk);
                checkOutput("fill_done_valid", {31'd0, m_valid}, 0);
                checkOutput("fill_beat_cnt", {16'd0, beat_cnt}, 3);
            end
        join
        waitDrain(10);
        stepCycles(1);

        $display("[TB] backpressure with 5 words");
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(16'h00A0 + 16'(i));
        stepCycles(6);
        @(negedge clk);
        checkOutput("bp_buf_count", {30'd0, buf_count}, 2);
        checkOutput("bp_rd_en", {31'd0, fifo_rd_en}, 0);
        checkOutput("bp_m_data", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h00A1});
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDrain(30);
        stepCycles(2);
        @(negedge clk);
        checkOutput("bp_after_count", {30'd0, buf_count}, 0);
        checkOutput("bp_after_beats", {16'd0, beat_cnt}, 8);
        @(posedge clk);
        #1;

        $display("[TB] single ready pulse with full buffer");
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(16'h00B0 + 16'(i));
        stepCycles(6);
        x0 = xfer_count;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        checkOutput("pulse_count_after_pop", {30'd0, buf_count}, 1);
        checkOutput("pulse_head", {16'd0, m_data}, 16'h00B2);
        @(negedge clk);
        checkOutput("pulse_count_refill", {30'd0, buf_count}, 2);
        checkOutput("pulse_one_xfer", xfer_count - x0, 1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDrain(30);
        stepCycles(2);

        $display("[TB] reset mid-stream");
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(16'h00C0 + 16'(i));
        stepCycles(6);
        @(negedge clk);
        checkOutput("mid_full_before_rst", {30'd0, buf_count}, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rd_en_during_rst", {31'd0, fifo_rd_en}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_m_valid", {31'd0, m_valid}, 0);
        checkOutput("mid_buf_count", {30'd0, buf_count}, 0);
        checkOutput("mid_beat_cnt", {16'd0, beat_cnt}, 0);
        checkOutput("mid_m_data", {16'd0, m_data}, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 1; i <= 3; i++) applyStimulus(16'h00D0 + 16'(i));
        waitDrain(20);
        stepCycles(2);
        @(negedge clk);
        checkOutput("restart_beat_cnt", {16'd0, beat_cnt}, 3);
        @(posedge clk);
        #1;

        $display("[TB] 65537 transfers for beat counter wrap");
        pulseReset();
        m_ready = 1'b1;
        for (int i = 1; i <= 65537; i++) applyStimulus(16'(i));
        waitDrain(50);
        stepCycles(2);
        @(negedge clk);
        checkOutput("wrap_beat_cnt", {16'd0, beat_cnt}, 1);
        checkOutput("wrap_idle_valid", {31'd0, m_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
